// File: rtl/rf_pkg.sv
// ============================================================================
// Module      : rf_pkg
// Description : Shared default sizes and data constants for the register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rf_pkg;

  localparam int c_rf_n     = 32;
  localparam int c_rf_depth = 32;
  localparam int c_rf_aw    = 5;

  localparam logic [c_rf_n-1:0] c_rf_zero = '0;

endpackage : rf_pkg

`default_nettype wire

// File: rtl/rf_entry.sv
// ============================================================================
// Module      : rf_entry
// Description : One register-file storage entry: N-bit load-enable register,
//               synchronous active-high reset taking priority over load.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_entry
  import rf_pkg::*;
#(
  parameter int N = c_rf_n
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= N'(c_rf_zero);
    end else if (load) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule : rf_entry

`default_nettype wire

// File: rtl/register_file.sv
// ============================================================================
// Module      : register_file
// Description : DEPTH x N register file, one write port, two combinational
//               read ports, x0 hardwired to zero. Optional same-cycle write
//               bypass enabled by macro RF_WRITE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file
  import rf_pkg::*;
#(
  parameter int N     = c_rf_n,
  parameter int DEPTH = c_rf_depth,
  parameter int AW    = c_rf_aw
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [N-1:0]  rdata1,
  output logic [N-1:0]  rdata2
);

  logic [N-1:0] w_q [DEPTH];
  logic         w_wr_nz;
  logic         w_byp1;
  logic         w_byp2;

  // x0 has no storage; it is a constant zero source for the read muxes.
  assign w_q[0]  = N'(c_rf_zero);
  assign w_wr_nz = we && (waddr != '0);

  generate
    for (genvar i = 1; i < DEPTH; i++) begin : g_entry
      logic w_load;
      assign w_load = we && (waddr == AW'(i));

      rf_entry #(
        .N (N)
      ) u_entry (
        .clk  (clk),
        .rst  (rst),
        .load (w_load),
        .d    (wdata),
        .q    (w_q[i])
      );
    end
  endgenerate

`ifdef RF_WRITE_BYPASS_EN
  // Forwarding ignores rst on purpose: the read reflects the write being presented.
  assign w_byp1 = w_wr_nz && (raddr1 == waddr);
  assign w_byp2 = w_wr_nz && (raddr2 == waddr);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  always_comb begin
    rdata1 = N'(c_rf_zero);
    rdata2 = N'(c_rf_zero);
    if (raddr1 != '0) begin
      rdata1 = w_byp1 ? wdata : w_q[raddr1];
    end
    if (raddr2 != '0) begin
      rdata2 = w_byp2 ? wdata : w_q[raddr2];
    end
  end

endmodule : register_file

`default_nettype wire

// File: tb/tb_register_file.sv
// ============================================================================
// Module      : tb_register_file
// Description : Scoreboard bench for register_file (directed + random traffic).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_file;

`ifdef RF_WRITE_BYPASS_EN
  localparam bit c_byp = 1'b1;
`else
  localparam bit c_byp = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;

  register_file #(
    .N     (32),
    .DEPTH (32),
    .AW    (5)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t        q_exp[$];
  logic [31:0] mem [32];
  int          n_pass;
  int          n_total;

  // Monitor: compares whatever the stimulus queued for the current cycle.
  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      exp_t e;
      e = q_exp.pop_front();
      n_total = n_total + 1;
      if (rdata1 === e.e1) n_pass = n_pass + 1;
      else $display("FAIL rd1 id=%0d addr=%0d got=%08h exp=%08h", e.id, e.a1, rdata1, e.e1);
      n_total = n_total + 1;
      if (rdata2 === e.e2) n_pass = n_pass + 1;
      else $display("FAIL rd2 id=%0d addr=%0d got=%08h exp=%08h", e.id, e.a2, rdata2, e.e2);
    end
  end

  // Drive one cycle; optionally queue expected reads; advance the reference model.
  task automatic step(input logic r, input logic w, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] a1,
                      input logic [4:0] a2, input bit chk, input int id,
                      input logic [31:0] e1, input logic [31:0] e2);
    exp_t e;
    rst = r; we = w; waddr = wa; wdata = wd; raddr1 = a1; raddr2 = a2;
    if (chk) begin
      e.id = id; e.a1 = a1; e.a2 = a2; e.e1 = e1; e.e2 = e2;
      q_exp.push_back(e);
    end
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < 32; k++) mem[k] = 32'h0;
    end else if (w && wa != 5'd0) begin
      mem[wa] = wd;
    end
    #1;
  endtask

  function automatic logic [31:0] model_rd(input logic w, input logic [4:0] wa,
                                           input logic [31:0] wd, input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (c_byp && w && wa == a) return wd;
    return mem[a];
  endfunction

  initial begin
    logic        rr, rw;
    logic [4:0]  rwa, ra1, ra2;
    logic [31:0] rwd;
    int          wait_cyc;

    n_pass = 0; n_total = 0;
    for (int k = 0; k < 32; k++) mem[k] = 32'h0;
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
    @(posedge clk); #1;

    // Reset, then every address on both ports reads zero.
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 32; i++)
      step(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 1'b1, 1, 32'h0, 32'h0);

    // Write x5, then read next cycle.
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd6, 1'b1, 2,
         c_byp ? 32'hDEADBEEF : 32'h0, 32'h0);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b1, 3, 32'hDEADBEEF, 32'hDEADBEEF);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd6, 5'd0, 1'b1, 4, 32'h0, 32'h0);

    // Write to x0 is ignored and never forwarded.
    step(1'b0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd5, 1'b1, 5, 32'h0, 32'hDEADBEEF);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd5, 1'b1, 6, 32'h0, 32'hDEADBEEF);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd31, 1'b1, 7, 32'h0, 32'h0);

    // Same-cycle read/write on x7.
    step(1'b0, 1'b1, 5'd7, 32'h11, 5'd7, 5'd0, 1'b1, 8, c_byp ? 32'h11 : 32'h0, 32'h0);
    step(1'b0, 1'b1, 5'd7, 32'h22, 5'd7, 5'd5, 1'b1, 9,
         c_byp ? 32'h22 : 32'h11, 32'hDEADBEEF);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b1, 10, 32'h22, 32'h22);

    // Reset wins over a simultaneous write.
    step(1'b0, 1'b1, 5'd3, 32'hAA, 5'd3, 5'd7, 1'b1, 11, c_byp ? 32'hAA : 32'h0, 32'h22);
    step(1'b1, 1'b1, 5'd3, 32'hBB, 5'd3, 5'd7, 1'b1, 12, c_byp ? 32'hBB : 32'hAA, 32'h22);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd7, 1'b1, 13, 32'h0, 32'h0);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b1, 14, 32'h0, 32'h0);

    // Random traffic against the reference model.
    for (int c = 0; c < 10000; c++) begin
      rr  = ($urandom_range(0, 99) == 0);
      rw  = ($urandom_range(0, 2) != 0);
      rwa = 5'($urandom_range(0, 31));
      rwd = $urandom;
      ra1 = ($urandom_range(0, 3) == 0) ? rwa : 5'($urandom_range(0, 31));
      ra2 = ($urandom_range(0, 3) == 0) ? rwa : 5'($urandom_range(0, 31));
      step(rr, rw, rwa, rwd, ra1, ra2, 1'b1, 100,
           model_rd(rw, rwa, rwd, ra1), model_rd(rw, rwa, rwd, ra2));
    end

    we = 1'b0; rst = 1'b0;
    wait_cyc = 0;
    while (q_exp.size() > 0 && wait_cyc < 4) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (q_exp.size() > 0) begin
      n_total = n_total + 1;
      $display("FAIL drain pending=%0d exp=0", q_exp.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_register_file

`default_nettype wire
